seq_array_multiplier: RTL

Parametrised sequential shift-add multiplier, the successor to the team's fixed 3x3 combinational array multiplier. It multiplies two WIDTH-bit operands over WIDTH+2 clock cycles, using one WIDTH-bit adder instead of a WIDTH² partial-product array. It adds a start/done handshake and a run-time signed (two's-complement) mode, and sits as a shared arithmetic unit behind a controller that issues one operation at a time.

---
 rtl/arith_pkg.sv | 15 +
 rtl/seq_array_multiplier_if.sv | 15 +
 rtl/fullAdder.sv | 11 +
 rtl/ripple_adder.sv | 25 ++
 rtl/seq_array_multiplier.sv | 104 ++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and the iteration-counter
// width for the sequential multiplier.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_array_multiplier_if.sv
// Start/done request bus for the shared sequential multiplier.
interface seq_array_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       x;
  logic [WIDTH-1:0]       y;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     p;

  modport master (output start, signed_mode, x, y, input busy, done, p);
  modport slave  (input start, signed_mode, x, y, output busy, done, p);
endinterface

// File: rtl/fullAdder.sv
// One-bit full adder cell, the building block of the ripple adder.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder with carry-out, chained from fullAdder cells.
module ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fullAdder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end
endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential shift-add multiplier: WIDTH iterations of one shared adder,
// with optional two's-complement operands handled by sign-magnitude.
module seq_array_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  seq_array_multiplier_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   raw;

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_hi_q),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign sum = mplier_q[0] ? {add_cout, add_sum} : {1'b0, acc_hi_q};
  assign raw = {acc_hi_q, mplier_q};

  // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_hi_d = acc_hi_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Magnitudes fit WIDTH unsigned bits, even for the most negative operand.
          mcand_d  = (bus.signed_mode && bus.x[WIDTH-1]) ? ~bus.x + WIDTH'(1) : bus.x;
          mplier_d = (bus.signed_mode && bus.y[WIDTH-1]) ? ~bus.y + WIDTH'(1) : bus.y;
          neg_d    = bus.signed_mode & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        {acc_hi_d, mplier_d} = {sum, mplier_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        p_d     = neg_q ? ~raw + (2*WIDTH)'(1) : raw;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
  // NOTE: all registers, p included, reset so an aborted operation leaves no stale product visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_hi_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      p_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_hi_q <= acc_hi_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule
